sample_pacer: RTL and testbench
===============================

# sample_pacer

Rate-controlled drain for the circular buffer read port. Pulls one word from the buffer every `div+1` clock cycles and presents it on a valid/ready output stream, for example to a DAC or serializer. Empty-buffer ticks are counted as underruns, and a substitute word is still emitted so the downstream rate stays constant. The block sits between the buffer's `rd_en`/`rd_data`/`empty` port and the sample consumer.

## Interface
- `DATA_WIDTH`, 8, word width; must match the buffer.
- `DIV_WIDTH`, 16, width of the rate divider.
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run/stop control.
- `div`  in  DIV_WIDTH  tick period minus one, in cycles.
- `fifo_rd_en`  out  1  buffer pop strobe; combinational.
- `fifo_rd_data`  in  DATA_WIDTH  buffer head word, valid whenever `!fifo_empty` (show-ahead).
- `fifo_empty`  in  1  buffer empty flag.
- `out_valid`  out  1  output word valid.
- `out_data`  out  DATA_WIDTH  output word.
- `out_ready`  in  1  consumer accepts the word.
- `underrun_cnt`  out  16  count of underrun ticks; saturating.
- `busy`  out  1  high when state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and PRESENT.
- IDLE:
  - `cnt <= div`, `pending <= 0`, `out_valid` low, no pops.
  - Moves to WAIT when `enable` is sampled high.
- Divider:
  - In WAIT and PRESENT, `cnt` decrements each cycle.
  - `tick = (cnt == 0)`. On a tick, `cnt <= div`.
  - `div` is sampled only on reload, so mid-period changes take effect from the next period.
- Fetch:
  - A fetch happens in WAIT when `tick || pending`.
  - `fifo_rd_en = fetch && !fifo_empty`.
  - At the same edge, `out_data <= fifo_rd_data`.
  - The FSM then moves to PRESENT, and `pending` clears unless a tick coincides with a pending fetch, in which case `pending` stays set.
- Underrun:
  - Occurs when a fetch happens with `fifo_empty` high.
  - No pop. `underrun_cnt` increments, saturating at 16'hFFFF.
  - The substitute word is governed by the Configuration section. The FSM still moves to PRESENT.
- PRESENT:
  - `out_valid` is high and `out_data` is stable until `out_valid && out_ready`.
  - On acceptance, the FSM moves to WAIT, or to IDLE if `enable` is low.
  - A tick during PRESENT sets `pending`. Further ticks while `pending` is already set are dropped.
- Enable handling:
  - `enable` low is acted on only in WAIT (go to IDLE) and at PRESENT acceptance.
  - An in-flight word is never abandoned.
- `fifo_rd_en` is never asserted outside WAIT, never with `fifo_empty` high, and at most once per fetch.

## Timing
- All outputs reset to 0; state resets to IDLE.
- First output:
  - `enable` sampled high at cycle T means WAIT at T+1 with `cnt = div`.
  - The tick and pop occur at T+1+div.
  - `out_valid` goes high at T+2+div.
- Steady state with `out_ready` held high: one word per `div+1` cycles, for `div >= 1`.
- `div = 0`:
  - A tick occurs every cycle, and the pending flag keeps the pipeline full.
  - Throughput is one word per 2 cycles. Excess ticks are dropped and are not counted as underruns.
- Acceptance to next pop is one cycle minimum (the PRESENT→WAIT transition).
- If `reset_n` is asserted mid-PRESENT, the word is discarded and `out_valid` drops asynchronously.

## Configuration
- `SAMPLE_PACER_UNDERRUN_HOLD_EN`
  - Defined: on underrun, `out_data` keeps its previous value, so the last sample is repeated.
  - Undefined: on underrun, `out_data <= 0` (silence).
- In both cases `out_valid` asserts and `underrun_cnt` increments.

## Test plan
- Reset and enable:
  - Stimulus: reset, then `enable=1`, `div=3`, buffer holding 0x11, 0x22, `out_ready=1`.
  - Response: `fifo_rd_en` pulses at T+4 and T+8; `out_data` shows 0x11, then 0x22; `underrun_cnt = 0`.
- Underrun:
  - Stimulus: empty buffer, `div=2`, last word 0x5A.
  - Response: a tick gives `out_valid` with 0x5A (HOLD defined) or 0x00 (undefined); `underrun_cnt` reads 1, then 2 on the next tick; `fifo_rd_en` never asserts.
- Backpressure:
  - Stimulus: `div=1`, `out_ready=0` for 6 cycles, full buffer.
  - Response: `out_data` is stable while held; exactly one pop after release (pending); the dropped tick is not counted as an underrun.
- Maximum rate:
  - Stimulus: `div=0`, `out_ready=1`, 8 words queued.
  - Response: 8 words are emitted in order, one every 2 cycles.
- Disable during PRESENT:
  - Stimulus: drop `enable` while `out_valid=1` and `out_ready=0`, then raise `out_ready`.
  - Response: the word is accepted, then IDLE with `busy=0`; no further pops.
- Asynchronous reset:
  - Stimulus: assert `reset_n=0` between clock edges while in PRESENT.
  - Response: `out_valid`, `busy` and `underrun_cnt` go to 0 immediately.

Source files
------------

// File: rtl/sample_pacer.sv
// sample_pacer: rate-controlled drain for a show-ahead circular buffer read port.
// Emits one word every div+1 cycles on a valid/ready stream. When the buffer is
// empty at a tick, it counts an underrun and emits a substitute word instead.
// Optional build macro: SAMPLE_PACER_UNDERRUN_HOLD_EN. When it is defined, an
// underrun repeats the last word. When it is undefined, an underrun emits zero.
module sample_pacer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [15:0]           underrun_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 pending;
    logic                 tick;
    logic                 fetch;
    logic                 underrun;

    // Divider tick, fetch decision and the strobes/status derived from state
    always_comb begin
        tick       = (state != S_IDLE) && (cnt == '0);
        fetch      = (state == S_WAIT) && (tick || pending);
        underrun   = fetch && fifo_empty;
        fifo_rd_en = fetch && !fifo_empty;
        out_valid  = (state == S_PRESENT);
        busy       = (state != S_IDLE);
    end

    // Next-state logic. A fetch wins over a disable in WAIT, so a word that
    // has already been popped is always presented.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (fetch)        state_nx = S_PRESENT;
                else if (!enable) state_nx = S_IDLE;
            end
            S_PRESENT: begin
                if (out_ready) state_nx = enable ? S_WAIT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Divider counter. div is sampled only on reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     cnt <= '0;
        else if (state == S_IDLE || tick) cnt <= div;
        else                              cnt <= cnt - DIV_WIDTH'(1);
    end

    // Pending fetch. A tick during PRESENT sets it. A fetch consumes it unless
    // a new tick lands on the same cycle. Any extra ticks are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else begin
            case (state)
                S_WAIT:    if (fetch) pending <= pending && tick;
                S_PRESENT: if (tick)  pending <= 1'b1;
                default:   pending <= 1'b0;
            endcase
        end
    end

    // Output word capture at fetch, with the underrun substitute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
        end else if (fetch) begin
`ifdef SAMPLE_PACER_UNDERRUN_HOLD_EN
            if (!fifo_empty) out_data <= fifo_rd_data;
`else
            out_data <= fifo_empty ? '0 : fifo_rd_data;
`endif
        end
    end

    // Saturating underrun counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            underrun_cnt <= '0;
        else if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Self-checking bench for sample_pacer. It uses a show-ahead FIFO model and a
// scoreboard of expected words, each tagged with the underrun count expected
// when that word is accepted.
module tb_sample_pacer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] div;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] underrun_cnt;
    logic        busy;

    typedef struct {
        logic [7:0] d;
        int         uc;
    } exp_t;

    exp_t       exp_q[$];
    int         uc_model = 0;
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] mem [0:63];
    int         wp = 0;
    int         rp = 0;

    sample_pacer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .div          (div),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Show-ahead buffer model
    assign fifo_empty   = (wp == rp);
    assign fifo_rd_data = mem[rp[5:0]];
    always @(posedge clk) if (fifo_rd_en) rp <= rp + 1;

`ifdef SAMPLE_PACER_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic [7:0] last_word = 8'h00;

    task automatic push_word(input logic [7:0] d);
        exp_t e;
        mem[wp[5:0]] = d;
        wp = wp + 1;
        e.d = d;
        e.uc = uc_model;
        exp_q.push_back(e);
        last_word = d;
    endtask

    task automatic push_sub();
        exp_t e;
        uc_model = uc_model + 1;
        e.d = HOLD ? last_word : 8'h00;
        e.uc = uc_model;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; div = 16'd3; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fails++; $display("FAIL rst_ucnt: got %0d want 0", underrun_cnt); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fails++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        n_checks++; if (out_data !== 8'h00) begin n_fails++; $display("FAIL rst_data: got %0h want 0", out_data); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_enable();
        exp_t e;
        int   seen = 0;
        push_word(8'h11);
        push_word(8'h22);
        div = 16'd3; out_ready = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_rd_en !== (k == 4 || k == 8)) begin
                n_fails++; $display("FAIL en_rd_en_k%0d: got %b want %b", k, fifo_rd_en, (k == 4 || k == 8));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++; $display("FAIL en_extra: got word %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL en_data: got %0h want %0h", out_data, e.d); end
                    n_checks++; if (underrun_cnt !== 16'(e.uc)) begin n_fails++; $display("FAIL en_ucnt: got %0d want %0d", underrun_cnt, e.uc); end
                    seen++;
                    if (seen == 2) enable = 1'b0;
                end
            end
        end
        n_checks++; if (seen != 2) begin n_fails++; $display("FAIL en_count: got %0d want 2", seen); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL en_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_underrun();
        exp_t e;
        int   seen = 0;
        int   pops = 0;
        int   b    = 0;
        push_word(8'h5A);
        push_sub();
        push_sub();
        div = 16'd2; out_ready = 1'b1; enable = 1'b1;
        while (seen < 3 && b < 60) begin
            @(negedge clk); b++;
            if (fifo_rd_en) begin
                pops++;
                n_checks++; if (fifo_empty) begin n_fails++; $display("FAIL ur_pop_empty: got rd_en=1 want 0"); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++; $display("FAIL ur_extra: got word %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL ur_data: got %0h want %0h", out_data, e.d); end
                    n_checks++; if (underrun_cnt !== 16'(e.uc)) begin n_fails++; $display("FAIL ur_ucnt: got %0d want %0d", underrun_cnt, e.uc); end
                    seen++;
                    if (seen == 3) enable = 1'b0;
                end
            end
        end
        n_checks++; if (seen != 3) begin n_fails++; $display("FAIL ur_count: got %0d want 3", seen); end
        n_checks++; if (pops != 1) begin n_fails++; $display("FAIL ur_pops: got %0d want 1", pops); end
        @(negedge clk);
        n_checks++; if (underrun_cnt !== 16'd2) begin n_fails++; $display("FAIL ur_final: got %0d want 2", underrun_cnt); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   seen = 0;
        int   b    = 0;
        logic [7:0] held;
        for (int i = 0; i < 4; i++) push_word(8'hA1 + 8'(i));
        div = 16'd1; out_ready = 1'b0; enable = 1'b1;
        while (!out_valid && b < 20) begin @(negedge clk); b++; end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_wait: got valid=%b want 1", out_valid); end
        held = exp_q[0].d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (out_data !== held || out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_hold: got %0h/%b want %0h/1", out_data, out_valid, held); end
            n_checks++; if (fifo_rd_en !== 1'b0) begin n_fails++; $display("FAIL bp_nopop: got %b want 0", fifo_rd_en); end
        end
        out_ready = 1'b1;
        #1;
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front(); seen++;
            n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL bp_data0: got %0h want %0h", out_data, e.d); end
        end else begin
            n_checks++; n_fails++; $display("FAIL bp_accept: got valid=%b want 1", out_valid);
        end
        @(negedge clk);
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fails++; $display("FAIL bp_pending_pop: got %b want 1", fifo_rd_en); end
        b = 0;
        while (seen < 4 && b < 40) begin
            @(negedge clk); b++;
            if (b == 1) begin
                n_checks++; if (fifo_rd_en !== 1'b0) begin n_fails++; $display("FAIL bp_single_pop: got %b want 0", fifo_rd_en); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++; $display("FAIL bp_extra: got word %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL bp_data: got %0h want %0h", out_data, e.d); end
                    n_checks++; if (underrun_cnt !== 16'(e.uc)) begin n_fails++; $display("FAIL bp_ucnt: got %0d want %0d", underrun_cnt, e.uc); end
                    seen++;
                    if (seen == 4) enable = 1'b0;
                end
            end
        end
        n_checks++; if (seen != 4) begin n_fails++; $display("FAIL bp_count: got %0d want 4", seen); end
        @(negedge clk);
    endtask

    task automatic test_max_rate();
        exp_t e;
        int   seen = 0;
        int   last = -1;
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        div = 16'd0; out_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 60 && seen < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++; $display("FAIL mr_extra: got word %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL mr_data: got %0h want %0h", out_data, e.d); end
                    if (last >= 0) begin
                        n_checks++; if (c - last != 2) begin n_fails++; $display("FAIL mr_spacing: got %0d want 2", c - last); end
                    end
                    last = c;
                    seen++;
                    if (seen == 8) enable = 1'b0;
                end
            end
        end
        n_checks++; if (seen != 8) begin n_fails++; $display("FAIL mr_count: got %0d want 8", seen); end
        @(negedge clk);
        n_checks++; if (underrun_cnt !== 16'd2) begin n_fails++; $display("FAIL mr_ucnt: got %0d want 2", underrun_cnt); end
    endtask

    task automatic test_disable_present();
        exp_t e;
        int   b    = 0;
        int   pops = 0;
        push_word(8'h77);
        push_word(8'h88);
        div = 16'd2; out_ready = 1'b0; enable = 1'b1;
        while (!out_valid && b < 20) begin @(negedge clk); b++; end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL dis_wait: got valid=%b want 1", out_valid); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL dis_held: got valid=%b want 1", out_valid); end
        out_ready = 1'b1;
        #1;
        if (out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL dis_data: got %0h want %0h", out_data, e.d); end
        end else begin
            n_checks++; n_fails++; $display("FAIL dis_accept: got valid=%b want 1", out_valid);
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fails++; $display("FAIL dis_idle: got busy=%b valid=%b want 0/0", busy, out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_rd_en) pops++;
        end
        n_checks++; if (pops != 0) begin n_fails++; $display("FAIL dis_nopop: got %0d want 0", pops); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   b = 0;
        div = 16'd2; out_ready = 1'b0; enable = 1'b1;
        while (!out_valid && b < 20) begin @(negedge clk); b++; end
        if (out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++; if (out_data !== e.d) begin n_fails++; $display("FAIL ar_data: got %0h want %0h", out_data, e.d); end
        end else begin
            n_checks++; n_fails++; $display("FAIL ar_wait: got valid=%b want 1", out_valid);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        uc_model = 0;
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL ar_busy: got %b want 0", busy); end
        n_checks++; if (underrun_cnt !== 16'(uc_model)) begin n_fails++; $display("FAIL ar_ucnt: got %0d want %0d", underrun_cnt, uc_model); end
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable();
        test_underrun();
        test_backpressure();
        test_max_rate();
        test_disable_present();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
